// File: rtl/ram_access_sequencer_pkg.sv
// Shared types for the ram access sequencer.
// State encoding and wait-count helper.
package ram_access_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RECOVER,
    S_RESP
  } state_e;

  // A zero wait would leave no cycle for the ram to respond.
  function automatic int eff_wait(input int w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ram_access_sequencer_wait_counter.sv
// Down-counter timing the ACCESS phase.
// Ports: clk, rst_n, load (start count), done (count exhausted).
module ram_wait_counter
  import ram_access_sequencer_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int EFF = eff_wait(WAIT_CYCLES);
  localparam int CW  = $clog2(EFF + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Loaded with EFF-1 so done rises in the last ACCESS cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(EFF - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ram_access_sequencer.sv
// Valid/ready front end for a single-port tristate ram.
// Ports: req_* in, rsp_* out, ram_* to the ram (ram_data inout).
module ram_access_sequencer
  import ram_access_sequencer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SIZE        = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  output logic              ram_chip_select,
  inout  wire  [WIDTH-1:0]  ram_data
);

  state_e state_q, state_d;
  logic              write_q, write_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_write_q, ram_write_d;
  logic              drive_en_q, drive_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic        load;
  logic        done;
  logic        in_range;
  logic [31:0] addr_ext;

  ram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .done (done)
  );

  assign addr_ext = 32'(req_addr);
  assign in_range = addr_ext < 32'(SIZE);

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    ram_address_d = ram_address_q;
    ram_cs_d      = ram_cs_q;
    ram_write_d   = ram_write_q;
    drive_en_d    = drive_en_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_err_d     = rsp_err_q;
    rsp_rdata_d   = rsp_rdata_q;
    load          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          wdata_d     = req_wdata;
          rsp_rdata_d = '0;
          if (in_range) begin
            state_d       = S_SETUP;
            ram_address_d = req_addr;
            ram_cs_d      = 1'b1;
            ram_write_d   = 1'b0;
          end else begin
            // Rejected: straight to response, ram untouched.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_write_d = req_write;
          end
        end
      end
      S_SETUP: begin
        state_d     = S_ACCESS;
        load        = 1'b1;
        ram_write_d = write_q;
        drive_en_d  = write_q;
      end
      S_ACCESS: begin
        if (done) begin
          state_d     = S_RECOVER;
          ram_cs_d    = 1'b0;
          ram_write_d = 1'b0;
          drive_en_d  = 1'b0;
          if (!write_q) begin
            rsp_rdata_d = ram_data;
          end
        end
      end
      S_RECOVER: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_write_d = write_q;
        rsp_err_d   = 1'b0;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_write_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      ram_address_q <= '0;
      ram_cs_q      <= 1'b0;
      ram_write_q   <= 1'b0;
      drive_en_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      ram_address_q <= ram_address_d;
      ram_cs_q      <= ram_cs_d;
      ram_write_q   <= ram_write_d;
      drive_en_q    <= drive_en_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = rsp_write_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign ram_address     = ram_address_q;
  assign ram_write       = ram_write_q;
  assign ram_chip_select = ram_cs_q;

  assign ram_data = drive_en_q ? wdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Directed bench for ram_access_sequencer (SIZE=200, W=2).
// Bus checks: bench drives a background value whenever the DUT must not.
module tb_ram_access_sequencer;

  localparam int W = 2;
  localparam logic [7:0] BG = 8'h3C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_write;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] ram_address;
  logic       ram_write;
  logic       ram_chip_select;
  wire  [7:0] ram_data;
  logic       tb_en = 1'b1;
  logic [7:0] tb_val = BG;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_addr = '0;

  assign ram_data = tb_en ? tb_val : 8'bz;

  always #5 clk = ~clk;

  ram_access_sequencer #(
    .WIDTH(8),
    .SIZE(200),
    .ADDR_W(8),
    .WAIT_CYCLES(W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_write      (rsp_write),
    .rsp_err        (rsp_err),
    .rsp_rdata      (rsp_rdata),
    .ram_address    (ram_address),
    .ram_write      (ram_write),
    .ram_chip_select(ram_chip_select),
    .ram_data       (ram_data)
  );

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rv;
    int         hold;
    logic       err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ram(input string ph, input logic cs,
                         input logic wr, input logic [7:0] a,
                         input logic [7:0] bus);
    chk({ph, "_cs"}, 32'(ram_chip_select), 32'(cs));
    chk({ph, "_wr"}, 32'(ram_write), 32'(wr));
    chk({ph, "_addr"}, 32'(ram_address), 32'(a));
    chk({ph, "_bus"}, 32'(ram_data), 32'(bus));
  endtask

  task automatic chk_rsp(input string ph, input logic v,
                         input logic w, input logic e,
                         input logic [7:0] rd);
    chk({ph, "_rsp_valid"}, 32'(rsp_valid), 32'(v));
    chk({ph, "_rsp_write"}, 32'(rsp_write), 32'(w));
    chk({ph, "_rsp_err"}, 32'(rsp_err), 32'(e));
    chk({ph, "_rsp_rdata"}, 32'(rsp_rdata), 32'(rd));
  endtask

  task automatic txn(input vec_t v);
    @(negedge clk);
    tb_en = 1'b1;
    tb_val = BG;
    req_valid = 1'b1;
    req_write = v.w;
    req_addr = v.a;
    req_wdata = v.d;
    rsp_ready = (v.hold == 0);
    #1 chk("idle_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~v.w;
    req_addr = ~v.a;
    req_wdata = ~v.d;
    if (!v.err) begin
      #1;
      chk_ram("setup", 1'b1, 1'b0, v.a, BG);
      chk("setup_req_ready", 32'(req_ready), 32'd0);
      chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        tb_en = !v.w;
        tb_val = v.rv;
        #1;
        chk_ram("access", 1'b1, v.w, v.a, v.w ? v.d : v.rv);
        chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      @(negedge clk);
      tb_en = 1'b1;
      tb_val = BG;
      #1;
      chk_ram("recover", 1'b0, 1'b0, v.a, BG);
      chk("recover_rsp_valid", 32'(rsp_valid), 32'd0);
      last_addr = v.a;
      @(negedge clk);
    end
    #1;
    chk_rsp("resp", 1'b1, v.w, v.err, v.exp_rd);
    chk("resp_req_ready", 32'(req_ready), 32'd0);
    chk_ram("resp", 1'b0, 1'b0, last_addr, BG);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (i == v.hold - 1) rsp_ready = 1'b1;
      #1;
      chk_rsp("hold", 1'b1, v.w, v.err, v.exp_rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk_rsp("done", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h12, 8'h00, 8'hA5, 0, 1'b0, 8'hA5};
    vecs[2] = '{1'b0, 8'h12, 8'h00, 8'hA5, 10, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 8'd250, 8'h00, 8'h77, 0, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 8'd199, 8'hC3, 8'h00, 0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'd200, 8'h00, 8'h55, 2, 1'b1, 8'h00};
    vecs[6] = '{1'b1, 8'hFF, 8'h66, 8'h00, 0, 1'b1, 8'h00};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h81, 0, 1'b0, 8'h81};
    vecs[8] = '{1'b1, 8'h00, 8'hFF, 8'h00, 3, 1'b0, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_rsp("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    chk_ram("reset", 1'b0, 1'b0, 8'h00, BG);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    // Pulse reset while idle
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_ram("pulse", 1'b0, 1'b0, 8'h00, BG);
    chk("pulse_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_rsp("pulse", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("pulse_rel_ready", 32'(req_ready), 32'd1);

    for (int k = 0; k < 9; k++) begin
      txn(vecs[k]);
    end

    // Reset in the 2nd ACCESS cycle of a write
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 8'h30;
    req_wdata = 8'h5A;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tb_en = 1'b0;
    @(negedge clk);
    #1 chk("abort_pre_bus", 32'(ram_data), 32'h5A);
    #1;
    tb_en = 1'b1;
    tb_val = BG;
    rst_n = 1'b0;
    #1;
    chk_ram("abort", 1'b0, 1'b0, 8'h00, BG);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    last_addr = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_cs", 32'(ram_chip_select), 32'd0);
    end
    txn('{1'b0, 8'h30, 8'h00, 8'h5A, 0, 1'b0, 8'h5A});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
